spi_wb_xfer_seq: RTL and testbench
==================================

Name: spi_wb_xfer_seq

Overview:
- Wishbone master that sits directly upstream of the simple_spi_top register interface.
- Converts a valid/ready byte command stream into the register-access sequence simple_spi needs: configure, write SPDR, poll SPSR, read SPDR.
- Returns each received MISO byte on a valid/ready response stream and drives a chip select framed by a last flag.
- Replaces ad-hoc Wishbone driving of the SPI core in the I2C/SPI wrapper.

Parameters:
- CPOL, 1'b0, SPI clock polarity written to SPCR[3].
- CPHA, 1'b0, SPI clock phase written to SPCR[2].
- SPR, 2'b00, clock divider low bits written to SPCR[1:0].
- ESPR, 2'b00, extended divider bits written to SPER[1:0].
- POLL_LIMIT, 255, maximum SPSR reads per byte before timeout (8-bit counter, 1..255).

Ports:
- wb_clk_i  in  1  single clock for all logic
- wb_rst_i  in  1  reset, synchronous, active-low
- cmd_valid_i  in  1  command byte valid
- cmd_ready_o  out  1  command byte accepted when valid&ready
- cmd_data_i  in  8  byte to shift out on MOSI
- cmd_last_i  in  1  deassert ss_n_o after this byte
- rsp_valid_o  out  1  response valid
- rsp_ready_i  in  1  response accepted when valid&ready
- rsp_data_o  out  8  byte captured from MISO
- rsp_err_o  out  1  poll timeout; rsp_data_o forced to 8'h00
- ss_n_o  out  1  active-low slave select
- busy_o  out  1  high in any state other than IDLE
- wbm_cyc_o  out  1  Wishbone cycle
- wbm_stb_o  out  1  Wishbone strobe
- wbm_we_o  out  1  Wishbone write enable
- wbm_adr_o  out  8  register address: SPCR=0, SPSR=1, SPDR=2, SPER=3
- wbm_dat_o  out  8  write data
- wbm_dat_i  in  8  read data
- wbm_ack_i  in  1  Wishbone acknowledge

Behaviour:
- Reset values (wb_rst_i==0 at an edge): cyc, stb, we, adr, dat_o = 0; cmd_ready_o=0; rsp_valid_o=0; rsp_err_o=0; rsp_data_o=8'h00; ss_n_o=1; busy_o=1; state=INIT_CTRL; poll counter=0.
- Reset mid-operation drops cyc/stb at that edge. No completion of the partial access is attempted.
- Wishbone rules:
  - cyc and stb assert together and are held with stable adr/we/dat_o until wbm_ack_i is sampled high.
  - Both deassert on the edge where ack is sampled.
  - At least one idle cycle follows before the next access.
  - ack while stb is low is ignored.
- FSM states and transitions:
  - INIT_CTRL: write SPCR = {1'b0, SPE=1, 1'b0, MSTR=1, CPOL, CPHA, SPR}; default value 8'h50. Go to INIT_EXT.
  - INIT_EXT: write SPER = {2'b00, 2'b00, 2'b00, ESPR}; default value 8'h00. Go to IDLE.
  - IDLE: cmd_ready_o=1, busy_o=0. On cmd_valid_i, latch data and last, drive ss_n_o=0 on the same edge, go to WR_DATA.
  - WR_DATA: write SPDR = latched byte. Clear poll counter, go to POLL.
  - POLL: read SPSR.
    - RFEMPTY (bit0)==0: go to RD_DATA.
    - Otherwise increment the counter. If the counter reaches POLL_LIMIT, go to FLUSH; else repeat POLL.
  - RD_DATA: read SPDR, capture wbm_dat_i into rsp_data_o, set rsp_err_o=0, go to RESP.
  - FLUSH: write SPCR = 8'h10 (SPE=0, which clears the core FIFOs). Set rsp_data_o=8'h00, rsp_err_o=1, force the latched last flag to 1, go to RESP.
  - RESP: rsp_valid_o=1, with data and err held stable until rsp_ready_i.
    - On handshake: if last, set ss_n_o=1. Next state is INIT_CTRL after a timeout, else IDLE.
- cmd_ready_o is high only in IDLE. A new command is never accepted while a response is pending.
- ss_n_o stays low across consecutive bytes until a byte with cmd_last_i=1 (or a timeout) completes its RESP handshake.
- Minimum per-byte latency with a 1-cycle-ack slave: accept→rsp_valid is 9 cycles with a single poll. Each extra poll adds 3 cycles.
- Simultaneous events:
  - rsp_ready_i high in the same cycle rsp_valid_o rises completes the handshake that cycle.
  - cmd_valid_i during RESP is ignored.

Decomposition:
- Package spi_wb_seq_pkg holds:
  - register address localparams SPCR/SPSR/SPDR/SPER;
  - SPCR/SPSR bit indices (SPE, MSTR, RFEMPTY);
  - the FLUSH constant 8'h10;
  - the state enum.
- One sub-module, wb_single_access: a one-shot Wishbone master with a req/we/adr/wdata in, done/rdata out interface, enforcing the hold-until-ack and idle-gap rules. The FSM lives in the top.

Test Plan:
- Release reset with a 1-cycle-ack model → writes adr 0 data 8'h50, then adr 3 data 8'h00. cmd_ready_o rises after that, ss_n_o=1 throughout.
- cmd 8'hA5 with last=1; slave returns RFEMPTY=0 on the first poll and SPDR=8'h3C → wbm write adr2=8'hA5. rsp 8'h3C, err=0, 9 cycles after acceptance. ss_n_o returns high after the handshake.
- Three bytes 8'h01, 8'h02, 8'h03 with last only on the third → ss_n_o stays low continuously until the third response handshake.
- Hold rsp_ready_i low for 20 cycles → rsp_valid_o and data stay stable, no Wishbone activity, cmd_ready_o=0.
- SPSR always returns 8'h05 → exactly 255 SPSR reads, then write adr0=8'h10. rsp err=1, data 8'h00, ss_n_o goes high, re-init writes 8'h50 and 8'h00.
- Assert wb_rst_i low during a held stb with no ack → cyc/stb are low the next cycle, ss_n_o=1, and the init sequence restarts after release.

Source files
------------

// File: rtl/spi_wb_xfer_seq_pkg.sv
// spi_wb_seq_pkg
// Shared constants and types for the simple_spi Wishbone transfer sequencer:
// register map of simple_spi_top, SPCR/SPSR bit positions, the FIFO flush
// control word, the sequencer state encoding, and a helper that assembles
// the SPCR enable word.
package spi_wb_seq_pkg;

    // simple_spi_top register addresses
    localparam logic [7:0] ADR_SPCR = 8'd0;
    localparam logic [7:0] ADR_SPSR = 8'd1;
    localparam logic [7:0] ADR_SPDR = 8'd2;
    localparam logic [7:0] ADR_SPER = 8'd3;

    // SPCR / SPSR bit indices
    localparam int SPCR_SPE     = 6;
    localparam int SPCR_MSTR    = 4;
    localparam int SPCR_CPOL    = 3;
    localparam int SPCR_CPHA    = 2;
    localparam int SPSR_RFEMPTY = 0;

    // Writing SPCR with SPE=0 disables the core, which clears its FIFOs
    localparam logic [7:0] SPCR_FLUSH = 8'h10;

    typedef enum logic [2:0] {
        ST_INIT_CTRL,
        ST_INIT_EXT,
        ST_IDLE,
        ST_WR_DATA,
        ST_POLL,
        ST_RD_DATA,
        ST_FLUSH,
        ST_RESP
    } state_t;

    // SPCR word that enables the core as master with the chosen mode/divider
    function automatic logic [7:0] spcr_enable(input logic cpol, input logic cpha,
                                               input logic [1:0] spr);
        logic [7:0] v;
        v            = 8'h00;
        v[SPCR_SPE]  = 1'b1;
        v[SPCR_MSTR] = 1'b1;
        v[SPCR_CPOL] = cpol;
        v[SPCR_CPHA] = cpha;
        v[1:0]       = spr;
        return v;
    endfunction

endpackage

// File: rtl/spi_wb_xfer_seq_if.sv
// spi_wb_xfer_seq_if
// Bundles the command stream, response stream and Wishbone master bus of the
// transfer sequencer.
//   cmd_*  : valid/ready byte commands into the sequencer (last closes frame)
//   rsp_*  : valid/ready MISO bytes out of the sequencer (err = poll timeout)
//   wbm_*  : Wishbone master towards simple_spi_top
// Modports: master = the sequencer, slave = its environment.
interface spi_wb_xfer_seq_if;

    logic       cmd_valid_i;
    logic       cmd_ready_o;
    logic [7:0] cmd_data_i;
    logic       cmd_last_i;

    logic       rsp_valid_o;
    logic       rsp_ready_i;
    logic [7:0] rsp_data_o;
    logic       rsp_err_o;

    logic       wbm_cyc_o;
    logic       wbm_stb_o;
    logic       wbm_we_o;
    logic [7:0] wbm_adr_o;
    logic [7:0] wbm_dat_o;
    logic [7:0] wbm_dat_i;
    logic       wbm_ack_i;

    modport master (
        input  cmd_valid_i, cmd_data_i, cmd_last_i, rsp_ready_i, wbm_dat_i, wbm_ack_i,
        output cmd_ready_o, rsp_valid_o, rsp_data_o, rsp_err_o,
               wbm_cyc_o, wbm_stb_o, wbm_we_o, wbm_adr_o, wbm_dat_o
    );

    modport slave (
        output cmd_valid_i, cmd_data_i, cmd_last_i, rsp_ready_i, wbm_dat_i, wbm_ack_i,
        input  cmd_ready_o, rsp_valid_o, rsp_data_o, rsp_err_o,
               wbm_cyc_o, wbm_stb_o, wbm_we_o, wbm_adr_o, wbm_dat_o
    );

endinterface

// File: rtl/spi_wb_xfer_seq_access.sv
// wb_single_access
// One-shot Wishbone master. A request (req/we/adr/wdata) launches a single
// access whose cyc/stb/we/adr/dat are held until ack is sampled; cyc/stb drop
// on that edge and done pulses combinationally in the ack cycle with rdata
// valid. Because a new access is only launched from a cycle where stb was
// already low, at least one idle cycle always separates two accesses.
// Ports: clk, rst_n (sync, active-low), req/we/adr/wdata in, done/rdata out,
//        cyc_o/stb_o/we_o/adr_o/dat_o/dat_i/ack_i Wishbone master side.
module wb_single_access (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       req,
    input  logic       we,
    input  logic [7:0] adr,
    input  logic [7:0] wdata,
    output logic       done,
    output logic [7:0] rdata,
    output logic       cyc_o,
    output logic       stb_o,
    output logic       we_o,
    output logic [7:0] adr_o,
    output logic [7:0] dat_o,
    input  logic [7:0] dat_i,
    input  logic       ack_i
);

    // Launch on an idle cycle, hold until ack; ack with stb low is ignored
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cyc_o <= 1'b0;
            stb_o <= 1'b0;
            we_o  <= 1'b0;
            adr_o <= 8'h00;
            dat_o <= 8'h00;
        end else if (stb_o) begin
            if (ack_i) begin
                cyc_o <= 1'b0;
                stb_o <= 1'b0;
            end
        end else if (req) begin
            cyc_o <= 1'b1;
            stb_o <= 1'b1;
            we_o  <= we;
            adr_o <= adr;
            dat_o <= wdata;
        end
    end

    assign done  = stb_o & ack_i;
    assign rdata = dat_i;

endmodule

// File: rtl/spi_wb_xfer_seq.sv
// spi_wb_xfer_seq
// Wishbone master sitting in front of simple_spi_top. After reset it writes
// SPCR and SPER, then for every command byte writes SPDR, polls SPSR until the
// read FIFO holds data (or POLL_LIMIT reads elapse), reads SPDR and returns the
// byte on the response stream. A timeout flushes the core, reports err with
// data 8'h00, closes the frame and re-initialises the core.
// Ports: wb_clk_i clock, wb_rst_i sync active-low reset, bus (cmd/rsp streams
//        and Wishbone master), ss_n_o active-low slave select, busy_o.
module spi_wb_xfer_seq
    import spi_wb_seq_pkg::*;
#(
    parameter logic       CPOL       = 1'b0,
    parameter logic       CPHA       = 1'b0,
    parameter logic [1:0] SPR        = 2'b00,
    parameter logic [1:0] ESPR       = 2'b00,
    parameter int         POLL_LIMIT = 255
) (
    input  logic                     wb_clk_i,
    input  logic                     wb_rst_i,
    spi_wb_xfer_seq_if.master        bus,
    output logic                     ss_n_o,
    output logic                     busy_o
);

    localparam logic [7:0] SPCR_INIT = spcr_enable(CPOL, CPHA, SPR);
    localparam logic [7:0] SPER_INIT = {6'b000000, ESPR};
    localparam logic [7:0] POLL_LIM8 = POLL_LIMIT[7:0];

    state_t     state, next_state;
    logic       acc_req, acc_we, acc_done;
    logic [7:0] acc_adr, acc_wdata, acc_rdata;
    logic [7:0] data_q, rsp_data_q, poll_cnt;
    logic [7:0] poll_next;
    logic       last_q, rsp_err_q, ss_n_q;
    logic       cmd_ready, rsp_valid, busy;

    assign poll_next = poll_cnt + 8'd1;

    wb_single_access u_access (
        .clk   (wb_clk_i),
        .rst_n (wb_rst_i),
        .req   (acc_req),
        .we    (acc_we),
        .adr   (acc_adr),
        .wdata (acc_wdata),
        .done  (acc_done),
        .rdata (acc_rdata),
        .cyc_o (bus.wbm_cyc_o),
        .stb_o (bus.wbm_stb_o),
        .we_o  (bus.wbm_we_o),
        .adr_o (bus.wbm_adr_o),
        .dat_o (bus.wbm_dat_o),
        .dat_i (bus.wbm_dat_i),
        .ack_i (bus.wbm_ack_i)
    );

    always_ff @(posedge wb_clk_i) begin
        if (!wb_rst_i) state <= ST_INIT_CTRL;
        else           state <= next_state;
    end

    // Each access state keeps req asserted; the transition happens on done
    always_comb begin
        next_state = state;
        acc_req    = 1'b0;
        acc_we     = 1'b0;
        acc_adr    = ADR_SPCR;
        acc_wdata  = 8'h00;
        cmd_ready  = 1'b0;
        rsp_valid  = 1'b0;
        busy       = 1'b1;
        case (state)
            ST_INIT_CTRL: begin
                acc_req = 1'b1; acc_we = 1'b1; acc_adr = ADR_SPCR; acc_wdata = SPCR_INIT;
                if (acc_done) next_state = ST_INIT_EXT;
            end
            ST_INIT_EXT: begin
                acc_req = 1'b1; acc_we = 1'b1; acc_adr = ADR_SPER; acc_wdata = SPER_INIT;
                if (acc_done) next_state = ST_IDLE;
            end
            ST_IDLE: begin
                cmd_ready = 1'b1;
                busy      = 1'b0;
                if (bus.cmd_valid_i) next_state = ST_WR_DATA;
            end
            ST_WR_DATA: begin
                acc_req = 1'b1; acc_we = 1'b1; acc_adr = ADR_SPDR; acc_wdata = data_q;
                if (acc_done) next_state = ST_POLL;
            end
            ST_POLL: begin
                acc_req = 1'b1; acc_adr = ADR_SPSR;
                if (acc_done) begin
                    if (!acc_rdata[SPSR_RFEMPTY]) next_state = ST_RD_DATA;
                    else if (poll_next == POLL_LIM8) next_state = ST_FLUSH;
                end
            end
            ST_RD_DATA: begin
                acc_req = 1'b1; acc_adr = ADR_SPDR;
                if (acc_done) next_state = ST_RESP;
            end
            ST_FLUSH: begin
                acc_req = 1'b1; acc_we = 1'b1; acc_adr = ADR_SPCR; acc_wdata = SPCR_FLUSH;
                if (acc_done) next_state = ST_RESP;
            end
            ST_RESP: begin
                rsp_valid = 1'b1;
                // err is only ever set by a timeout, so it selects re-init
                if (bus.rsp_ready_i) next_state = rsp_err_q ? ST_INIT_CTRL : ST_IDLE;
            end
            default: next_state = ST_INIT_CTRL;
        endcase
    end

    // Command latch, poll counter, response registers and frame select
    always_ff @(posedge wb_clk_i) begin
        if (!wb_rst_i) begin
            data_q     <= 8'h00;
            last_q     <= 1'b0;
            rsp_data_q <= 8'h00;
            rsp_err_q  <= 1'b0;
            ss_n_q     <= 1'b1;
            poll_cnt   <= 8'h00;
        end else begin
            case (state)
                ST_IDLE: if (bus.cmd_valid_i) begin
                    data_q <= bus.cmd_data_i;
                    last_q <= bus.cmd_last_i;
                    ss_n_q <= 1'b0;
                end
                ST_WR_DATA: poll_cnt <= 8'h00;
                ST_POLL: if (acc_done && acc_rdata[SPSR_RFEMPTY]) poll_cnt <= poll_next;
                ST_RD_DATA: if (acc_done) begin
                    rsp_data_q <= acc_rdata;
                    rsp_err_q  <= 1'b0;
                end
                ST_FLUSH: if (acc_done) begin
                    rsp_data_q <= 8'h00;
                    rsp_err_q  <= 1'b1;
                    last_q     <= 1'b1;
                end
                ST_RESP: if (bus.rsp_ready_i && last_q) ss_n_q <= 1'b1;
                default: ;
            endcase
        end
    end

    assign bus.cmd_ready_o = cmd_ready;
    assign bus.rsp_valid_o = rsp_valid;
    assign bus.rsp_data_o  = rsp_data_q;
    assign bus.rsp_err_o   = rsp_err_q;
    assign ss_n_o          = ss_n_q;
    assign busy_o          = busy;

endmodule

// File: tb/tb_spi_wb_xfer_seq.sv
// tb_spi_wb_xfer_seq
// Drives the sequencer against a behavioural simple_spi register model with a
// one-cycle registered ack. Expected Wishbone access lists, response bytes,
// latencies and slave-select behaviour come from a transaction-level model of
// the byte protocol, applied to a fixed vector table and to random bytes.
module tb_spi_wb_xfer_seq;
    import spi_wb_seq_pkg::*;

    typedef struct packed {
        logic       we;
        logic [7:0] adr;
        logic [7:0] dat;
    } acc_t;

    typedef struct {
        logic [7:0] data;
        bit         last;
        int         busy;
        logic [7:0] miso;
        int         delay;
        bit         pre_ready;
        logic [7:0] exp_data;
        bit         exp_err;
        bit         exp_ss;
        int         exp_lat;
    } vec_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic ss_n, busy;
    int   checks = 0;
    int   failures = 0;
    int   cycle = 0;
    int   ss_rise = 0;
    int   proto_errs = 0;

    always #5 clk = ~clk;

    spi_wb_xfer_seq_if bus();

    spi_wb_xfer_seq #(
        .CPOL(1'b0), .CPHA(1'b0), .SPR(2'b00), .ESPR(2'b00), .POLL_LIMIT(255)
    ) dut (
        .wb_clk_i (clk),
        .wb_rst_i (rst_n),
        .bus      (bus.master),
        .ss_n_o   (ss_n),
        .busy_o   (busy)
    );

    always @(posedge clk) cycle <= cycle + 1;
    always @(posedge ss_n) if (rst_n) ss_rise++;

    // simple_spi register model: SPSR reports RFEMPTY for cur_busy polls
    int         busy_q[$];
    logic [7:0] miso_q[$];
    int         cur_busy = 0;
    int         polls_done = 0;
    logic [7:0] cur_miso = 8'h00;
    bit         ack_en = 1'b1;
    acc_t       wb_log[$];
    acc_t       exp_log[$];

    assign bus.wbm_dat_i = (bus.wbm_adr_o == ADR_SPSR) ? ((polls_done < cur_busy) ? 8'h05 : 8'h04)
                         : (bus.wbm_adr_o == ADR_SPDR) ? cur_miso : 8'h00;

    always @(posedge clk) begin
        if (!rst_n) begin
            bus.wbm_ack_i <= 1'b0;
        end else begin
            if (bus.wbm_cyc_o && bus.wbm_stb_o && bus.wbm_ack_i) begin
                wb_log.push_back({bus.wbm_we_o, bus.wbm_adr_o, bus.wbm_we_o ? bus.wbm_dat_o : 8'h00});
                if (bus.wbm_we_o && bus.wbm_adr_o == ADR_SPDR) begin
                    polls_done <= 0;
                    cur_busy   <= (busy_q.size() > 0) ? busy_q.pop_front() : 0;
                    cur_miso   <= (miso_q.size() > 0) ? miso_q.pop_front() : 8'h00;
                end else if (!bus.wbm_we_o && bus.wbm_adr_o == ADR_SPSR) begin
                    polls_done <= polls_done + 1;
                end
            end
            bus.wbm_ack_i <= ack_en && bus.wbm_cyc_o && bus.wbm_stb_o && !bus.wbm_ack_i;
        end
    end

    // Wishbone rule monitor: hold until ack, drop on ack, cyc == stb
    logic       p_valid = 1'b0, p_stb = 1'b0, p_ack = 1'b0, p_we = 1'b0;
    logic [7:0] p_adr = 8'h00, p_dat = 8'h00;
    always @(posedge clk) begin
        if (rst_n && p_valid) begin
            if (bus.wbm_cyc_o !== bus.wbm_stb_o) proto_errs++;
            if (p_stb && !p_ack && (bus.wbm_stb_o !== 1'b1 || bus.wbm_we_o !== p_we ||
                bus.wbm_adr_o !== p_adr || bus.wbm_dat_o !== p_dat)) proto_errs++;
            if (p_stb && p_ack && bus.wbm_cyc_o !== 1'b0) proto_errs++;
        end
        p_valid = rst_n;
        p_stb   = bus.wbm_stb_o;
        p_ack   = bus.wbm_ack_i;
        p_we    = bus.wbm_we_o;
        p_adr   = bus.wbm_adr_o;
        p_dat   = bus.wbm_dat_o;
    end

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s actual=%0h expected=%0h", name, actual, expected);
        end
    endtask

    task automatic finishRun();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    endtask

    // Transaction-level model of the accesses one byte produces
    function automatic void modelByte(input logic [7:0] data, input int busy_polls);
        int polls;
        exp_log.delete();
        exp_log.push_back({1'b1, 8'd2, data});
        polls = (busy_polls + 1 > 255) ? 255 : busy_polls + 1;
        for (int i = 0; i < polls; i++) exp_log.push_back({1'b0, 8'd1, 8'h00});
        if (busy_polls >= 255) begin
            exp_log.push_back({1'b1, 8'd0, 8'h10});
            exp_log.push_back({1'b1, 8'd0, 8'h50});
            exp_log.push_back({1'b1, 8'd3, 8'h00});
        end else begin
            exp_log.push_back({1'b0, 8'd2, 8'h00});
        end
    endfunction

    task automatic compareLog(input string name);
        int mism;
        mism = -1;
        for (int i = 0; i < wb_log.size() && i < exp_log.size(); i++)
            if (mism < 0 && wb_log[i] !== exp_log[i]) mism = i;
        checkOutput({name, "_wb_len"}, wb_log.size(), exp_log.size());
        checkOutput({name, "_wb_seq"}, mism, -1);
        wb_log.delete();
    endtask

    task automatic waitReady(input string name, input bit check_ss_high);
        int  n;
        bit  ss_ok;
        n = 0;
        ss_ok = 1'b1;
        do begin
            @(negedge clk);
            if (ss_n !== 1'b1) ss_ok = 1'b0;
            n++;
        end while (bus.cmd_ready_o !== 1'b1 && n < 100);
        if (bus.cmd_ready_o !== 1'b1) begin
            checkOutput({name, "_ready_timeout"}, 0, 1);
            finishRun();
        end
        if (check_ss_high) checkOutput({name, "_ss_high"}, ss_ok, 1);
        compareLog(name);
    endtask

    // Expects to be entered at a negedge with cmd_ready_o high
    task automatic applyStimulus(input vec_t v, input string name);
        int         acc, n, logsz, rise0;
        bit         stable;
        logic [7:0] d0;
        logic       e0;
        modelByte(v.data, v.busy);
        busy_q.push_back(v.busy);
        miso_q.push_back(v.miso);
        rise0 = ss_rise;
        bus.cmd_valid_i = 1'b1;
        bus.cmd_data_i  = v.data;
        bus.cmd_last_i  = v.last;
        bus.rsp_ready_i = v.pre_ready;
        @(negedge clk);
        acc = cycle;
        bus.cmd_valid_i = 1'b0;
        bus.cmd_data_i  = 8'h00;
        checkOutput({name, "_ss_low"}, ss_n, 1'b0);
        n = 0;
        while (bus.rsp_valid_o !== 1'b1 && n < 2000) begin
            @(negedge clk);
            n++;
        end
        if (bus.rsp_valid_o !== 1'b1) begin
            checkOutput({name, "_rsp_timeout"}, 0, 1);
            finishRun();
        end
        checkOutput({name, "_latency"}, cycle - acc, v.exp_lat);
        checkOutput({name, "_data"}, bus.rsp_data_o, v.exp_data);
        checkOutput({name, "_err"}, bus.rsp_err_o, v.exp_err);
        d0 = bus.rsp_data_o;
        e0 = bus.rsp_err_o;
        logsz = wb_log.size();
        stable = 1'b1;
        if (!v.pre_ready && v.delay > 0) begin
            bus.cmd_valid_i = 1'b1;
            bus.cmd_data_i  = 8'hEE;
            for (int i = 0; i < v.delay; i++) begin
                @(negedge clk);
                if (bus.rsp_valid_o !== 1'b1 || bus.rsp_data_o !== d0 || bus.rsp_err_o !== e0 ||
                    bus.wbm_cyc_o !== 1'b0 || bus.cmd_ready_o !== 1'b0) stable = 1'b0;
            end
            bus.cmd_valid_i = 1'b0;
            checkOutput({name, "_hold_stable"}, stable, 1);
            checkOutput({name, "_hold_no_wb"}, wb_log.size(), logsz);
        end
        bus.rsp_ready_i = 1'b1;
        @(negedge clk);
        bus.rsp_ready_i = 1'b0;
        checkOutput({name, "_rsp_drop"}, bus.rsp_valid_o, 1'b0);
        checkOutput({name, "_ss_after"}, ss_n, v.exp_ss);
        checkOutput({name, "_ss_rises"}, ss_rise - rise0, v.exp_ss ? 1 : 0);
        waitReady(name, 1'b0);
    endtask

    vec_t vecs[8];

    initial begin
        #500000;
        checkOutput("global_watchdog", 0, 1);
        finishRun();
    end

    initial begin
        vec_t rv;
        int   polls;
        bus.cmd_valid_i = 1'b0;
        bus.cmd_data_i  = 8'h00;
        bus.cmd_last_i  = 1'b0;
        bus.rsp_ready_i = 1'b0;

        //            data  last busy miso  dly pre  exp   err ss  lat
        vecs[0] = '{8'hA5, 1'b1, 0,   8'h3C, 0,  1'b0, 8'h3C, 1'b0, 1'b1, 9};
        vecs[1] = '{8'h01, 1'b0, 0,   8'h11, 0,  1'b0, 8'h11, 1'b0, 1'b0, 9};
        vecs[2] = '{8'h02, 1'b0, 1,   8'h22, 0,  1'b1, 8'h22, 1'b0, 1'b0, 12};
        vecs[3] = '{8'h03, 1'b1, 2,   8'h33, 0,  1'b0, 8'h33, 1'b0, 1'b1, 15};
        vecs[4] = '{8'h5A, 1'b0, 0,   8'hC3, 20, 1'b0, 8'hC3, 1'b0, 1'b0, 9};
        vecs[5] = '{8'h77, 1'b1, 0,   8'hE1, 0,  1'b1, 8'hE1, 1'b0, 1'b1, 9};
        vecs[6] = '{8'h99, 1'b0, 255, 8'hAA, 0,  1'b0, 8'h00, 1'b1, 1'b1, 771};
        vecs[7] = '{8'h66, 1'b1, 254, 8'hBB, 0,  1'b0, 8'hBB, 1'b0, 1'b1, 771};

        repeat (3) @(posedge clk);
        @(negedge clk);
        checkOutput("rst_cyc", bus.wbm_cyc_o, 1'b0);
        checkOutput("rst_stb", bus.wbm_stb_o, 1'b0);
        checkOutput("rst_we", bus.wbm_we_o, 1'b0);
        checkOutput("rst_adr", bus.wbm_adr_o, 8'h00);
        checkOutput("rst_dat", bus.wbm_dat_o, 8'h00);
        checkOutput("rst_cmd_ready", bus.cmd_ready_o, 1'b0);
        checkOutput("rst_rsp_valid", bus.rsp_valid_o, 1'b0);
        checkOutput("rst_rsp_err", bus.rsp_err_o, 1'b0);
        checkOutput("rst_rsp_data", bus.rsp_data_o, 8'h00);
        checkOutput("rst_ss_n", ss_n, 1'b1);
        checkOutput("rst_busy", busy, 1'b1);

        rst_n = 1'b1;
        exp_log.delete();
        exp_log.push_back({1'b1, 8'd0, 8'h50});
        exp_log.push_back({1'b1, 8'd3, 8'h00});
        waitReady("init", 1'b1);
        checkOutput("idle_busy", busy, 1'b0);

        for (int i = 0; i < 8; i++) applyStimulus(vecs[i], $sformatf("vec%0d", i));

        for (int i = 0; i < 30; i++) begin
            rv.data      = 8'($urandom);
            rv.last      = ($urandom_range(0, 2) == 0);
            rv.busy      = ($urandom_range(0, 9) == 0) ? 255 : int'($urandom_range(0, 6));
            rv.miso      = 8'($urandom);
            rv.pre_ready = ($urandom_range(0, 3) == 0);
            rv.delay     = int'($urandom_range(0, 3));
            polls        = (rv.busy + 1 > 255) ? 255 : rv.busy + 1;
            rv.exp_err   = (rv.busy >= 255);
            rv.exp_data  = rv.exp_err ? 8'h00 : rv.miso;
            rv.exp_ss    = rv.last || rv.exp_err;
            rv.exp_lat   = 6 + 3 * polls;
            applyStimulus(rv, $sformatf("rnd%0d", i));
        end

        // Reset while an access is held without ack
        ack_en = 1'b0;
        busy_q.push_back(0);
        miso_q.push_back(8'h00);
        bus.cmd_valid_i = 1'b1;
        bus.cmd_data_i  = 8'h42;
        bus.cmd_last_i  = 1'b1;
        @(negedge clk);
        bus.cmd_valid_i = 1'b0;
        repeat (4) @(negedge clk);
        checkOutput("midrst_stb_held", bus.wbm_stb_o, 1'b1);
        checkOutput("midrst_adr_held", bus.wbm_adr_o, 8'h02);
        checkOutput("midrst_ss_low", ss_n, 1'b0);
        rst_n = 1'b0;
        @(negedge clk);
        checkOutput("midrst_cyc", bus.wbm_cyc_o, 1'b0);
        checkOutput("midrst_stb", bus.wbm_stb_o, 1'b0);
        checkOutput("midrst_ss_n", ss_n, 1'b1);
        ack_en = 1'b1;
        busy_q.delete();
        miso_q.delete();
        wb_log.delete();
        @(negedge clk);
        rst_n = 1'b1;
        exp_log.delete();
        exp_log.push_back({1'b1, 8'd0, 8'h50});
        exp_log.push_back({1'b1, 8'd3, 8'h00});
        waitReady("reinit", 1'b1);

        checkOutput("wb_protocol", proto_errs, 0);
        finishRun();
    end

endmodule
